// File: rtl/dst40_round_ctrl.sv
// DST40 round sequencer: owns the challenge shift register and key LFSR and
// steps them through ROUNDS rounds against an external round-function network.
module dst40_round_ctrl #(
  parameter int ROUNDS     = 200,
  parameter int KEY_PERIOD = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [39:0] key_in,
  input  logic [39:0] chal_in,
  output logic [39:0] f_chal,
  output logic [39:0] f_key,
  input  logic [1:0]  f_res,
  output logic        busy,
  output logic        done,
  output logic [23:0] resp,
  output logic [7:0]  round
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [7:0] LAST_ROUND = 8'(ROUNDS - 1);
  localparam logic [1:0] KCNT_LAST  = 2'(KEY_PERIOD - 1);

  state_t      state;
  logic [1:0]  kcnt;
  logic [39:0] chal;
  logic [39:0] key;
  logic [39:0] chal_next;
  logic [39:0] key_next;

  assign chal_next = {f_res ^ chal[1:0], chal[39:2]};
  assign key_next  = {key[0] ^ key[2] ^ key[19] ^ key[21], key[39:1]};

  assign f_chal = chal;
  assign f_key  = key;

  // Abort in RUN takes priority over the round update, leaving chal/key/round frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      chal  <= '0;
      key   <= '0;
      round <= '0;
      kcnt  <= '0;
      resp  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            chal  <= chal_in;
            key   <= key_in;
            round <= '0;
            kcnt  <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            chal  <= chal_next;
            round <= round + 8'd1;
            if (kcnt == KCNT_LAST) begin
              kcnt <= '0;
              key  <= key_next;
            end else begin
              kcnt <= kcnt + 2'd1;
            end
            if (round == LAST_ROUND) begin
              resp  <= chal_next[23:0];
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dst40_round_ctrl.sv
// Randomized bench for dst40_round_ctrl against a round-by-round behavioural model.
module tb_dst40_round_ctrl;

  localparam int ROUNDS     = 200;
  localparam int KEY_PERIOD = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [39:0] key_in = '0;
  logic [39:0] chal_in = '0;
  logic [1:0]  f_res = '0;
  logic [39:0] f_chal;
  logic [39:0] f_key;
  logic        busy;
  logic        done;
  logic [23:0] resp;
  logic [7:0]  round;

  int checks = 0;
  int passed = 0;
  logic [1:0] fresQ[$];

  dst40_round_ctrl #(.ROUNDS(ROUNDS), .KEY_PERIOD(KEY_PERIOD)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .key_in(key_in), .chal_in(chal_in), .f_chal(f_chal), .f_key(f_key),
    .f_res(f_res), .busy(busy), .done(done), .resp(resp), .round(round)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual === expected) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  function automatic logic [39:0] rand40();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[39:0];
  endfunction

  function automatic logic [39:0] keyStep(input logic [39:0] k);
    return {k[0] ^ k[2] ^ k[19] ^ k[21], k[39:1]};
  endfunction

  // Key after n rounds: one LFSR step per completed KEY_PERIOD block of rounds.
  function automatic logic [39:0] modelKey(input logic [39:0] k0, input int n);
    logic [39:0] k;
    k = k0;
    for (int i = 0; i < n / KEY_PERIOD; i++) k = keyStep(k);
    return k;
  endfunction

  // Challenge after n rounds, using the recorded f_res per round (0 if none recorded).
  function automatic logic [39:0] modelChal(input logic [39:0] c0, input int n);
    logic [39:0] c;
    logic [1:0]  fr;
    c = c0;
    for (int r = 0; r < n; r++) begin
      fr = (r < fresQ.size()) ? fresQ[r] : 2'b00;
      c  = {fr ^ c[1:0], c[39:2]};
    end
    return c;
  endfunction

  task automatic applyStimulus(input logic [39:0] k, input logic [39:0] c);
    @(negedge clk);
    key_in  = k;
    chal_in = c;
    start   = 1'b1;
    fresQ.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic runToDone(input bit randomRes, output int busyCnt, output int doneCnt);
    busyCnt = 0;
    doneCnt = 0;
    for (int cyc = 0; cyc < ROUNDS + 20; cyc++) begin
      if (doneCnt > 0 && !done) break;
      if (done) doneCnt++;
      if (busy) begin
        busyCnt++;
        f_res = randomRes ? 2'($urandom()) : 2'b00;
        fresQ.push_back(f_res);
      end else begin
        f_res = 2'b00;
      end
      @(negedge clk);
    end
    f_res = 2'b00;
  endtask

  task automatic waitRound(input int n);
    for (int cyc = 0; cyc < ROUNDS + 5 && round != 8'(n); cyc++) @(negedge clk);
    checkOutput("reach round", round, n);
  endtask

  task automatic cancelRun();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("busy after abort", busy, 0);
  endtask

  task automatic doRandomRun();
    logic [39:0] k, c, expChal;
    int bc, dc;
    k = rand40();
    c = rand40();
    applyStimulus(k, c);
    checkOutput("load f_chal", f_chal, c);
    checkOutput("load f_key", f_key, k);
    checkOutput("busy after start", busy, 1);
    runToDone(1'b1, bc, dc);
    expChal = modelChal(c, ROUNDS);
    checkOutput("rand busy cycles", bc, ROUNDS);
    checkOutput("rand done pulses", dc, 1);
    checkOutput("rand resp", resp, expChal[23:0]);
    checkOutput("rand f_key final", f_key, modelKey(k, ROUNDS));
    checkOutput("rand round final", round, ROUNDS);
  endtask

  initial begin
    logic [39:0] kA, cA, cB, kB, expC;
    int bc, dc;

    // Reset values
    #1 rst_n = 1'b0;
    #10;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset resp", resp, 0);
    checkOutput("reset round", round, 0);
    checkOutput("reset f_chal", f_chal, 0);
    checkOutput("reset f_key", f_key, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Null round function: 400 bits of rotation is identity
    applyStimulus(40'h0, 40'h12_3456_789A);
    runToDone(1'b0, bc, dc);
    checkOutput("null busy cycles", bc, ROUNDS);
    checkOutput("null done pulses", dc, 1);
    checkOutput("null resp", resp, 24'h56789A);
    checkOutput("null f_key", f_key, 0);

    // Key schedule
    applyStimulus(40'h00_0000_0001, 40'h0);
    checkOutput("ksched r0", f_key, 40'h1);
    for (int r = 1; r <= 6; r++) begin
      @(negedge clk);
      checkOutput($sformatf("ksched after r%0d", r), f_key,
                  (r < 3) ? 40'h1 : (r < 6) ? 40'h80_0000_0000 : 40'h40_0000_0000);
    end
    cancelRun();

    // Challenge feedback
    applyStimulus(40'h0, 40'h0);
    f_res = 2'b11;
    @(negedge clk);
    f_res = 2'b00;
    checkOutput("feedback r0", f_chal, 40'hC0_0000_0000);
    @(negedge clk);
    checkOutput("feedback r1", f_chal, 40'h30_0000_0000);
    cancelRun();

    // Abort: seed resp first, then cancel mid-run
    applyStimulus(40'h0, 40'h00_00AB_CDEF);
    runToDone(1'b0, bc, dc);
    checkOutput("seed resp", resp, 24'hABCDEF);
    kA = rand40();
    cA = rand40();
    applyStimulus(kA, cA);
    waitRound(51);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort round", round, 51);
    checkOutput("abort resp", resp, 24'hABCDEF);
    checkOutput("abort f_chal", f_chal, modelChal(cA, 51));
    checkOutput("abort f_key", f_key, modelKey(kA, 51));
    dc = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) dc++;
      @(negedge clk);
    end
    checkOutput("abort no done", dc, 0);

    // Start while busy is ignored
    kB = rand40();
    cB = rand40();
    applyStimulus(kB, cB);
    waitRound(5);
    key_in  = ~kB;
    chal_in = ~cB;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("busy-start f_chal", f_chal, modelChal(cB, 6));
    checkOutput("busy-start f_key", f_key, modelKey(kB, 6));
    runToDone(1'b0, bc, dc);
    checkOutput("busy-start resp", resp, cB[23:0]);
    checkOutput("busy-start done", dc, 1);

    // Start together with abort in IDLE: no load
    chal_in = rand40();
    key_in  = rand40();
    start   = 1'b1;
    abort   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    checkOutput("collision busy", busy, 0);
    checkOutput("collision f_chal", f_chal, cB);
    @(negedge clk);
    checkOutput("collision busy later", busy, 0);

    // Start in DONE is ignored; following IDLE cycle restarts
    applyStimulus(40'h0, 40'h55_0F0F_A5A5);
    for (int cyc = 0; cyc < ROUNDS + 10 && !done; cyc++) @(negedge clk);
    checkOutput("done seen", done, 1);
    chal_in = 40'hFF_FFFF_FFFF;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("done-start busy", busy, 0);
    checkOutput("done-start f_chal", f_chal, 40'h55_0F0F_A5A5);
    expC = rand40();
    chal_in = expC;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("restart busy", busy, 1);
    checkOutput("restart f_chal", f_chal, expC);
    cancelRun();

    // Async reset mid-run
    applyStimulus(rand40(), rand40());
    waitRound(120);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("areset busy", busy, 0);
    checkOutput("areset done", done, 0);
    checkOutput("areset resp", resp, 0);
    checkOutput("areset round", round, 0);
    checkOutput("areset f_chal", f_chal, 0);
    checkOutput("areset f_key", f_key, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized full runs
    for (int n = 0; n < 4; n++) doRandomRun();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
